nibble_serial_adder_ctrl: RTL and testbench
===========================================

# nibble_serial_adder_ctrl

Multi-cycle controller that sequences one shared 4-bit `ripple_adder` instance to add or subtract wide operands, one nibble per clock.

- The carry is registered between nibbles.
- Operands are captured on a start handshake.
- The full-width result, carry-out and signed overflow are presented with a one-cycle `done` pulse.
- Sits between register-file/ALU control and the 4-bit adder datapath, trading latency for adder area.

## Interface
Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES (legal range 2..16).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset; one clock (`clk`), synchronous, active-high.
- start  in  1  request; sampled only when state is IDLE or DONE.
- sub  in  1  0 = A+B, 1 = A−B; captured with `start`.
- A  in  W  operand A; captured with `start`.
- B  in  W  operand B; captured with `start`.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse; Sum/Cout/Ovf are valid and newly updated.
- Sum  out  W  result register; holds until the next completion.
- Cout  out  1  final carry out of the MSB nibble; for `sub`, 1 = no borrow (A ≥ B unsigned).
- Ovf  out  1  two's-complement signed overflow of the W-bit operation.

## Operation
- One internal `ripple_adder` instance. Its inputs are:
  - A: the selected nibble of the captured A.
  - B: the selected nibble of the captured B_eff, where B_eff = B when sub=0, ~B when sub=1.
  - Cin: the carry register.
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE, start=1:
  - Capture A, sub and B_eff.
  - idx ← 0; carry ← sub.
  - Next state RUN.
- IDLE/DONE, start=0: DONE → IDLE; IDLE stays.
- RUN, each cycle:
  - Write adder Sum into accumulator nibble idx.
  - carry ← adder Cout; idx ← idx+1.
- RUN, when idx = NIBBLES−1:
  - Load Sum ← accumulator with the final nibble merged.
  - Cout ← adder Cout.
  - Ovf ← (A[W−1] ~^ B_eff[W−1]) & (final Sum[W−1] ^ A[W−1]).
  - Next state DONE.
- Arithmetic is modulo 2^W. No saturation.
- `start` in RUN is ignored: no queueing, no error flag, and the in-flight operation is unaffected.
- Operand inputs A, B and sub may change freely after the capture edge.
- Sum, Cout and Ovf change only at the completion edge; partial nibbles are never visible on Sum.

## Timing
- Reset values: busy=0, done=0, Sum=0, Cout=0, Ovf=0. Internal idx, carry and accumulator are all 0.
- Reset mid-operation: abort at that edge with no `done` pulse, state IDLE, outputs return to reset values.
- Reset has priority over `start` on the same edge.
- Edge numbering: E0 is the edge at which `start` is accepted.
  - E1..E_NIBBLES: nibbles 0..NIBBLES−1 are processed.
  - busy is high from after E0 to after E_NIBBLES (NIBBLES cycles).
  - done is high for exactly the cycle after E_NIBBLES; Sum/Cout/Ovf update at E_NIBBLES.
- Latency: NIBBLES cycles from the accept edge to `done`.
- Back-to-back throughput: a new start may be accepted at the DONE-cycle edge, giving one result every NIBBLES+1 cycles.
- When a new start is accepted in DONE:
  - done drops the next cycle.
  - Sum holds the old value until the next completion.
- No combinational path from inputs to outputs.

## Test plan
- NIBBLES=4, A=0x1234, B=0x4321, sub=0:
  - busy high 4 cycles after E0.
  - done at cycle E4.
  - Sum=0x5555, Cout=0, Ovf=0.
- A=0xFFFF, B=0x0001, sub=0 → Sum=0x0000, Cout=1, Ovf=0.
- A=0x7FFF, B=0x0001, sub=0 → Sum=0x8000, Cout=0, Ovf=1.
- Subtraction:
  - 0x0005−0x0007 → Sum=0xFFFE, Cout=0, Ovf=0.
  - 0x8000−0x0001 → Sum=0x7FFF, Cout=1, Ovf=1.
- Start/handshake corner cases:
  - `start` held high continuously with changing A/B: each result matches the operands captured at its accept edge, and accepts occur every 5 cycles.
  - `start` pulsed mid-RUN: ignored, and the original result is unchanged.
- rst asserted at E2 of an operation → no done; all outputs 0 next cycle; a fresh start afterward completes correctly.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract controller.
// One shared 4-bit ripple adder processes a W = 4*NIBBLES bit operation,
// one nibble per clock, least-significant nibble first. The carry between
// nibbles is held in a register. The result is published with a one-cycle
// done pulse.

// 4-bit ripple-carry adder slice shared by the controller.
module ripple_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [4:0] c;

  // Four chained full adders; c[i] is the carry into bit i.
  always_comb begin
    c[0] = cin_i;
    for (int i = 0; i < 4; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = c[4];
  end

endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] Sum,
  output logic                 Cout,
  output logic                 Ovf
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;      // holds B_eff (B or ~B)
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [3:0]      add_sum;
  logic            add_cout;
  logic [W-1:0]    acc_merged;

  ripple_adder u_adder (
    .a_i    (a_q[{idx_q, 2'b00} +: 4]),
    .b_i    (b_q[{idx_q, 2'b00} +: 4]),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Next-state logic: operand capture, per-nibble accumulation, completion.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    acc_merged = acc_q;
    acc_merged[{idx_q, 2'b00} +: 4] = add_sum;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = sub ? ~B : B;
          idx_d   = '0;
          carry_d = sub;          // +1 completes the two's-complement negate
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d   = acc_merged;
        carry_d = add_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          sum_d   = acc_merged;
          cout_d  = add_cout;
          ovf_d   = (a_q[W-1] ~^ b_q[W-1]) & (acc_merged[W-1] ^ a_q[W-1]);
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; reset beats start on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl (NIBBLES = 4, 16-bit operands).
// A cycle-level behavioural model computes results with plain integer
// arithmetic and is compared against the DUT on every falling edge;
// directed operations also check hand-computed literal results.

module tb_nibble_serial_adder_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovf;

  int n_checks = 0;
  int n_pass   = 0;

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout),
    .Ovf   (Ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Expected result of a W-bit add/subtract from integer arithmetic.
  function automatic void calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                               output logic [W-1:0] r, output logic c, output logic o);
    longint sa, sb, sr, ua, ub, ur;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - (longint'(1) << W) : ua;
    sb = b[W-1] ? ub - (longint'(1) << W) : ub;
    if (s) begin
      ur = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      ur = ua + ub;
      c  = (ur >= (longint'(1) << W));
      sr = sa + sb;
    end
    r = ur[W-1:0];
    o = (sr > (longint'(1) << (W-1)) - 1) || (sr < -(longint'(1) << (W-1)));
  endfunction

  // Behavioural model: cycles remaining in the current operation plus the
  // pending result that becomes visible when the count reaches zero.
  logic         m_valid = 1'b0;
  int           m_left;
  logic         m_busy, m_done, m_cout, m_ovf;
  logic [W-1:0] m_sum;
  logic [W-1:0] p_sum;
  logic         p_cout, p_ovf;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_left  = 0;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
    end else if (m_valid) begin
      if (m_left != 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_sum  = p_sum;
          m_cout = p_cout;
          m_ovf  = p_ovf;
        end
      end else begin
        m_done = 1'b0;
        if (start) begin
          calc(A, B, sub, p_sum, p_cout, p_ovf);
          m_left = NIBBLES;
          m_busy = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("Sum",  32'(Sum),  32'(m_sum));
      check("Cout", 32'(Cout), 32'(m_cout));
      check("Ovf",  32'(Ovf),  32'(m_ovf));
    end
  end

  // Present an operation for one accept edge; returns at the negedge after it.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    A = a; B = b; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for the done pulse; n = falling edges waited.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic run_lit(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] e_sum, input logic e_c, input logic e_o);
    int n;
    start_op(a, b, s);
    wait_done(n);
    check({name, "_sum"},  32'(Sum),  32'(e_sum));
    check({name, "_cout"}, 32'(Cout), 32'(e_c));
    check({name, "_ovf"},  32'(Ovf),  32'(e_o));
  endtask

  logic [W-1:0] held_a [8] = '{16'h1111, 16'hA5A5, 16'h7FFF, 16'h0003,
                               16'h8000, 16'hFFFF, 16'h0F0F, 16'h4000};
  logic [W-1:0] held_b [8] = '{16'h2222, 16'h5A5A, 16'h8001, 16'h0009,
                               16'h0001, 16'hFFFF, 16'hF0F0, 16'h4000};

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_sum",  32'(Sum),  32'(0));

    // Basic addition with timing.
    start_op(16'h1234, 16'h4321, 1'b0);
    check("first_busy", 32'(busy), 32'(1));
    wait_done(n);
    check("latency", 32'(n), 32'(NIBBLES));
    check("add_sum",  32'(Sum),  32'(16'h5555));
    check("add_cout", 32'(Cout), 32'(0));
    check("add_ovf",  32'(Ovf),  32'(0));

    run_lit("wrap",    16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_lit("posovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_lit("borrow",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_lit("subovf",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // start held high with operands changing every cycle.
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 24; i++) begin
      A   = held_a[i % 8];
      B   = held_b[(i + 3) % 8];
      sub = i[0];
      @(negedge clk);
    end
    start = 1'b0;
    wait_done(n);
    @(negedge clk);

    // start pulsed mid-RUN must be ignored.
    start_op(16'h1234, 16'h4321, 1'b0);
    A = 16'hFFFF; B = 16'hFFFF; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("ignore_sum",  32'(Sum),  32'(16'h5555));
    check("ignore_cout", 32'(Cout), 32'(0));
    @(negedge clk);
    check("ignore_idle", 32'(busy), 32'(0));

    // Reset sampled at E2 aborts the operation.
    start_op(16'h0F00, 16'h00F0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_sum",  32'(Sum),  32'(0));
    check("abort_cout", 32'(Cout), 32'(0));
    check("abort_ovf",  32'(Ovf),  32'(0));
    repeat (6) begin
      @(negedge clk);
      check("abort_nodone", 32'(done), 32'(0));
    end

    run_lit("fresh", 16'h0F00, 16'h00F0, 1'b0, 16'h0FF0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
